// File: rtl/hazard_detection_unit_pkg.sv
// Shared encodings for the hazard detection unit: RV32 opcodes and divide FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hazard_detection_unit_pkg;

    localparam logic [6:0] STORE_OPCODE  = 7'b0100011;
    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;
    localparam logic [6:0] R_TYPE_OPCODE = 7'b0110011;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DIV_WAIT = 1'b1
    } div_state_e;

endpackage

// File: rtl/hazard_detection_unit_div_stall_counter.sv
// Divide hold sequencer: holds the pipeline front for DIV_CYCLES-1 cycles per divide.
// Latency: hold is combinational on EXE_IS_DIV; result-valid pulses on the release cycle.
// Backpressure: EXE_IS_DIV is ignored while a divide is in flight. Built only with MDU_STALL_EN.
`ifdef MDU_STALL_EN
module div_stall_counter
    import hazard_detection_unit_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic exe_is_div,
    output logic hold,
    output logic div_result_valid
);

    // First hold cycle happens in IDLE, so the counter covers the remaining DIV_CYCLES-2 holds.
    localparam logic [5:0] CNT_INIT = (DIV_CYCLES > 1) ? 6'(DIV_CYCLES - 2) : 6'd0;

    div_state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    // State and down-counter registers; reset aborts any hold in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Mealy outputs; all outputs forced low while reset is asserted.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        hold             = 1'b0;
        div_result_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exe_is_div) begin
                    if (DIV_CYCLES > 1) begin
                        hold    = 1'b1;
                        state_d = ST_DIV_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        // Single-cycle divide: the result is ready in the same cycle.
                        div_result_valid = 1'b1;
                    end
                end
            end
            ST_DIV_WAIT: begin
                if (cnt_q != 6'd0) begin
                    hold  = 1'b1;
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    div_result_valid = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst) begin
            hold             = 1'b0;
            div_result_valid = 1'b0;
        end
    end

endmodule
`endif

// File: rtl/hazard_detection_unit.sv
// Pipeline stall controller: load-use bubble plus optional multi-cycle divide hold (MDU_STALL_EN).
// Latency: zero cycles, all stall/bubble/valid outputs are combinational from inputs and state.
// Backpressure: divide hold overrides load-use; STALL_CYCLES counts PC stall cycles, wrapping.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_ADDR1,
    input  logic [4:0]  ID_ADDR2,
    input  logic        ID_OP1SEL,
    input  logic        ID_OP2SEL,
    input  logic [6:0]  ID_OPCODE,
    input  logic [4:0]  EXE_ADDR,
    input  logic        EXE_MEM_READ,
    input  logic        EXE_IS_DIV,
    output logic        PC_STALL,
    output logic        IF_ID_STALL,
    output logic        ID_EXE_STALL,
    output logic        ID_EXE_BUBBLE,
    output logic        DIV_RESULT_VALID,
    output logic [31:0] STALL_CYCLES
);

    if (DIV_CYCLES < 1 || DIV_CYCLES > 64) begin : g_bad_div_cycles
        $error("DIV_CYCLES must be in 1..64");
    end

    logic        is_branch;
    logic        is_store;
    logic        rs1_used;
    logic        rs2_used;
    logic        load_use;
    logic        hold;
    logic        div_valid;
    logic [31:0] stall_cycles_q, stall_cycles_d;

`ifdef MDU_STALL_EN
    div_stall_counter #(
        .DIV_CYCLES       (DIV_CYCLES)
    ) u_div_stall_counter (
        .clk              (CLK),
        .rst              (RESET),
        .exe_is_div       (EXE_IS_DIV),
        .hold             (hold),
        .div_result_valid (div_valid)
    );
`else
    // Single-cycle divider: never hold, result is valid whenever a divide sits in EXE.
    assign hold      = 1'b0;
    assign div_valid = EXE_IS_DIV & ~RESET;
`endif

    // Load-use detection and stall/bubble output mux; store data (rs2) is resolved later at MEM.
    always_comb begin
        is_branch = (ID_OPCODE == BRANCH_OPCODE);
        is_store  = (ID_OPCODE == STORE_OPCODE);
        rs1_used  = ~ID_OP1SEL | is_branch;
        rs2_used  = (~ID_OP2SEL | is_branch) & ~is_store;
        load_use  = EXE_MEM_READ & (EXE_ADDR != 5'd0) &
                    ((rs1_used & (ID_ADDR1 == EXE_ADDR)) |
                     (rs2_used & (ID_ADDR2 == EXE_ADDR)));

        PC_STALL         = ~RESET & (hold | load_use);
        IF_ID_STALL      = ~RESET & (hold | load_use);
        ID_EXE_STALL     = ~RESET & hold;
        ID_EXE_BUBBLE    = ~RESET & load_use & ~hold;
        DIV_RESULT_VALID = div_valid;

        stall_cycles_d   = stall_cycles_q + {31'd0, PC_STALL};
    end

    // Stall cycle counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign STALL_CYCLES = stall_cycles_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit with DIV_CYCLES=4.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
// Divide sequences are checked in the MDU_STALL_EN build, single-cycle behaviour otherwise.
module tb_hazard_detection_unit;
    import hazard_detection_unit_pkg::*;

    localparam logic [6:0] I_TYPE_OPCODE = 7'b0010011;

    logic        clk;
    logic        rst;
    logic [4:0]  id_addr1, id_addr2, exe_addr;
    logic        id_op1sel, id_op2sel, exe_mem_read, exe_is_div;
    logic [6:0]  id_opcode;
    logic        pc_stall, if_id_stall, id_exe_stall, id_exe_bubble, div_result_valid;
    logic [31:0] stall_cycles;

    // {pc, if_id, id_exe_stall, bubble, valid, stall_cycles}
    logic [36:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cnt = 0;

    hazard_detection_unit #(.DIV_CYCLES(4)) dut (
        .CLK              (clk),
        .RESET            (rst),
        .ID_ADDR1         (id_addr1),
        .ID_ADDR2         (id_addr2),
        .ID_OP1SEL        (id_op1sel),
        .ID_OP2SEL        (id_op2sel),
        .ID_OPCODE        (id_opcode),
        .EXE_ADDR         (exe_addr),
        .EXE_MEM_READ     (exe_mem_read),
        .EXE_IS_DIV       (exe_is_div),
        .PC_STALL         (pc_stall),
        .IF_ID_STALL      (if_id_stall),
        .ID_EXE_STALL     (id_exe_stall),
        .ID_EXE_BUBBLE    (id_exe_bubble),
        .DIV_RESULT_VALID (div_result_valid),
        .STALL_CYCLES     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs and queue the expected response for that cycle.
    task automatic step(input string nm, input logic r,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic s1, input logic s2, input logic [6:0] op,
                        input logic [4:0] ea, input logic mr, input logic dv,
                        input logic [4:0] flags);
        @(posedge clk);
        #1;
        rst = r; id_addr1 = a1; id_addr2 = a2; id_op1sel = s1; id_op2sel = s2;
        id_opcode = op; exe_addr = ea; exe_mem_read = mr; exe_is_div = dv;
        if (r) exp_cnt = 0;
        exp_q.push_back({flags, exp_cnt});
        name_q.push_back(nm);
        if (flags[4] && !r) exp_cnt = exp_cnt + 1;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [36:0] e, g;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = {pc_stall, if_id_stall, id_exe_stall, id_exe_bubble, div_result_valid, stall_cycles};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                         n, g[36:32], g[31:0], e[36:32], e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; id_addr1 = 0; id_addr2 = 0; id_op1sel = 0; id_op2sel = 0;
        id_opcode = R_TYPE_OPCODE; exe_addr = 0; exe_mem_read = 0; exe_is_div = 0;

        //       name            rst a1  a2  s1 s2 opcode         ea  mr dv  pc/ifid/idex/bub/vld
        step("reset",            1, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 0, 5'b00000);
        step("load_use_rs2",     0, 5,  1,  0, 0, R_TYPE_OPCODE, 1,  1, 0, 5'b11010);
        step("load_gone",        0, 5,  1,  0, 0, R_TYPE_OPCODE, 1,  0, 0, 5'b00000);
        step("load_x0",          0, 0,  3,  0, 0, R_TYPE_OPCODE, 0,  1, 0, 5'b00000);
        step("store_rs2",        0, 3,  7,  0, 0, STORE_OPCODE,  7,  1, 0, 5'b00000);
        step("op1sel_rs1",       0, 9,  2,  1, 1, I_TYPE_OPCODE, 9,  1, 0, 5'b00000);
        step("branch_rs2_imm",   0, 4,  6,  1, 1, BRANCH_OPCODE, 6,  1, 0, 5'b11010);
        step("load_use_rs1",     0, 12, 2,  0, 0, R_TYPE_OPCODE, 12, 1, 0, 5'b11010);
`ifdef MDU_STALL_EN
        step("div_hold1",        0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b11100);
        step("div_hold2_lu",     0, 8,  0,  0, 0, R_TYPE_OPCODE, 8,  1, 1, 5'b11100);
        step("div_hold3",        0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b11100);
        step("div_release",      0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b00001);
        step("b2b_hold1",        0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b11100);
        step("b2b_hold2",        0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b11100);
        step("b2b_hold3",        0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b11100);
        step("b2b_release",      0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b00001);
        step("div_idle",         0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 0, 5'b00000);
        step("rst_div_hold1",    0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b11100);
        step("rst_mid_hold",     1, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b00000);
        step("post_rst_hold1",   0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b11100);
        step("post_rst_hold2",   0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b11100);
        step("post_rst_hold3",   0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b11100);
        step("post_rst_release", 0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b00001);
        step("final_idle",       0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 0, 5'b00000);
`else
        step("div_single",       0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b00001);
        step("div_with_lu",      0, 8,  0,  0, 0, R_TYPE_OPCODE, 8,  1, 1, 5'b11011);
        step("div_again",        0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b00001);
        step("rst_with_div",     1, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 1, 5'b00000);
        step("post_rst_lu",      0, 2,  0,  0, 0, R_TYPE_OPCODE, 2,  1, 0, 5'b11010);
        step("final_idle",       0, 0,  0,  0, 0, R_TYPE_OPCODE, 0,  0, 0, 5'b00000);
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Pipeline stall controller for the RV32IM 5-stage core. It covers the data hazards that operand forwarding cannot resolve. A load in EXE whose destination is read by the instruction in ID produces a one-cycle bubble. A divide/remainder in EXE holds the front of the pipeline for a fixed multi-cycle latency. It sits beside `forwarding_unit`, consumes the same ID/EXE register addresses, and drives the stall/bubble controls of the PC, IF/ID and ID/EXE pipeline registers.

## Interface
- `DIV_CYCLES`, default 32: total cycles a DIV/DIVU/REM/REMU instruction occupies EXE. Legal range 1..64.
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `ID_ADDR1` in 5: rs1 of the instruction in ID.
- `ID_ADDR2` in 5: rs2 of the instruction in ID.
- `ID_OP1SEL` in 1: 1 = operand 1 is PC, not rs1.
- `ID_OP2SEL` in 1: 1 = operand 2 is immediate, not rs2.
- `ID_OPCODE` in 7: opcode of the instruction in ID.
- `EXE_ADDR` in 5: rd of the instruction in EXE.
- `EXE_MEM_READ` in 1: the EXE instruction is a load.
- `EXE_IS_DIV` in 1: the EXE instruction is a divide/remainder.
- `PC_STALL` out 1: hold the PC.
- `IF_ID_STALL` out 1: hold the IF/ID register.
- `ID_EXE_STALL` out 1: hold the ID/EXE register (divide hold).
- `ID_EXE_BUBBLE` out 1: load a NOP into ID/EXE (load-use).
- `DIV_RESULT_VALID` out 1: single-cycle pulse on the divide release cycle.
- `STALL_CYCLES` out 32: count of cycles in which `PC_STALL` was high.

## Operation
- Register use in ID:
  - rs1 is used when `ID_OP1SEL`=0 or `ID_OPCODE`=BRANCH.
  - rs2 is used when `ID_OP2SEL`=0 or `ID_OPCODE`=BRANCH.
  - STORE rs2 (store data) never counts as used; `forwarding_unit` resolves it at MEM via DATAMEMSEL.
- Load-use condition: `EXE_MEM_READ` & `EXE_ADDR`≠0 & a used rs matches `EXE_ADDR`.
  - Result: `PC_STALL`=`IF_ID_STALL`=`ID_EXE_BUBBLE`=1 for that cycle only.
  - Next cycle the load is in MEM and forwarding delivers the data.
- FSM states: IDLE, DIV_WAIT. A 6-bit down-counter `CNT` runs alongside.
  - IDLE, `EXE_IS_DIV`=1, `DIV_CYCLES`>1: HOLD=1; next state DIV_WAIT; `CNT`<=`DIV_CYCLES`-2.
  - IDLE, `DIV_CYCLES`=1: no hold, no state change.
  - DIV_WAIT, `CNT`≠0: HOLD=1; `CNT`<=`CNT`-1.
  - DIV_WAIT, `CNT`=0: HOLD=0; `DIV_RESULT_VALID`=1; next state IDLE.
- HOLD drives `PC_STALL`=`IF_ID_STALL`=`ID_EXE_STALL`=1.
- Priority: HOLD overrides load-use. `ID_EXE_BUBBLE`=0 whenever HOLD=1.
- `EXE_IS_DIV` is ignored in DIV_WAIT. Back-to-back divides restart from IDLE on the cycle after release.
- `STALL_CYCLES` increments on each clock edge at which `PC_STALL`=1. It wraps modulo 2^32.

## Timing
- Stall, bubble and `DIV_RESULT_VALID` outputs are combinational (Mealy) from current inputs plus state. There is zero-cycle latency from hazard to stall.
- Divide hold lasts exactly `DIV_CYCLES`-1 cycles. The divide spends `DIV_CYCLES` cycles in EXE.
- Reset values: state=IDLE, `CNT`=0, `STALL_CYCLES`=0. While `RESET`=1, all stall, bubble and valid outputs are 0.
- Reset asserted during DIV_WAIT aborts the hold immediately, with no `DIV_RESULT_VALID` pulse.

## Configuration
- `MDU_STALL_EN` defined:
  - The divide FSM, `CNT` and `DIV_RESULT_VALID` logic are present.
- `MDU_STALL_EN` undefined:
  - `EXE_IS_DIV` is ignored and `ID_EXE_STALL` is tied 0.
  - `DIV_RESULT_VALID` is tied 1 whenever `EXE_IS_DIV`=1 (single-cycle divider).
  - Only load-use stalls and `STALL_CYCLES` remain.

## Structure
- Opcode constants (STORE_OPCODE, BRANCH_OPCODE, R_TYPE_OPCODE) come from `utils/encodings.v`.
- The FSM state encodings are added to `utils/encodings.v`.
- The `assert` macro for benches comes from `utils/macros.v`.
- Sub-module `div_stall_counter` holds the FSM, `CNT`, HOLD and `DIV_RESULT_VALID`, compiled only under `MDU_STALL_EN`.
- The top level holds the load-use comparator and `STALL_CYCLES`.

## Test plan
- Load-use: `EXE_MEM_READ`=1, `EXE_ADDR`=1, `ID_ADDR2`=1, R-type, `OP2SEL`=0.
  - Expect `PC_STALL`=`IF_ID_STALL`=`ID_EXE_BUBBLE`=1 for one cycle, then 0 once `EXE_MEM_READ`=0.
  - Expect `STALL_CYCLES`=1.
- Suppressed cases, each expecting all outputs 0:
  - Load to x0 with `ID_ADDR1`=0.
  - STORE with only rs2 matching.
  - `ID_OP1SEL`=1 with rs1 matching.
- Divide, `DIV_CYCLES`=4: `EXE_IS_DIV`=1 held.
  - Expect HOLD high for 3 cycles, then `DIV_RESULT_VALID`=1 and HOLD=0 on the 4th.
  - Expect `STALL_CYCLES`=3.
- Divide with `DIV_CYCLES`=1: expect no hold.
- Back-to-back divides (`DIV_CYCLES`=4): `EXE_IS_DIV` stays 1 across release.
  - Expect hold 3, release, hold 3, release.
  - Expect no spurious re-trigger on the release cycle.
- Reset: assert `RESET` in cycle 2 of a `DIV_CYCLES`=32 hold.
  - Expect all outputs 0 immediately, no valid pulse, and `STALL_CYCLES`=0.
  - After deassert with `EXE_IS_DIV`=1, the FSM restarts from IDLE.
